count_direction_decoder: RTL and testbench

Receive-side companion to the 8-bit up/down counter. Samples the counter's `count` bus every enabled clock and recovers the counting direction from the value sequence alone. Validates each step as +1, −1 or hold, and flags wrap-around and direction reversals. Counts illegal steps. Sits beside the counter in self-checking benches and in designs that need the direction without access to `mode`.

---
 rtl/count_direction_decoder.sv | 227 ++++++++++++++++++++++
 tb/tb_count_direction_decoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/count_direction_decoder.sv
// ---------------------------------------------------------------------------
// count_direction_decoder
//
// Purpose:
//   Observes the value bus of an up/down counter and recovers the counting
//   direction from the sequence of sampled values alone.
//
//   Each enabled sample is compared against the previous enabled sample:
//     * a step of +1 establishes the UP direction,
//     * a step of -1 (mod 2^WIDTH) establishes the DOWN direction,
//     * a step of 0 is a hold,
//     * anything else is an illegal step.
//
//   The block also flags wrap-around steps (MAX->0 and 0->MAX) and legal steps
//   that go against the established direction (reversals). It keeps
//   saturating counts of illegal steps and reversals.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous, active-high reset
//   en_i         sample enable; count_in_i is only evaluated when en_i = 1
//   count_in_i   observed counter value (WIDTH bits)
//   dir_o        recovered direction, 1 = up, 0 = down (valid with dir_valid_o)
//   dir_valid_o  direction established by a legal +/-1 step
//   hold_o       one-cycle pulse: sample equals previous sample
//   step_err_o   one-cycle pulse: step is not 0, +1 or -1
//   wrap_up_o    one-cycle pulse: step from MAX to 0
//   wrap_down_o  one-cycle pulse: step from 0 to MAX
//   rev_o        one-cycle pulse: legal step against the established direction
//   err_cnt_o    saturating count of step_err_o events (ECW bits)
//   rev_cnt_o    saturating count of rev_o events (ECW bits)
//
// All outputs are driven directly from registers.
// ---------------------------------------------------------------------------
module count_direction_decoder #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned ECW   = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] count_in_i,
   output logic             dir_o,
   output logic             dir_valid_o,
   output logic             hold_o,
   output logic             step_err_o,
   output logic             wrap_up_o,
   output logic             wrap_down_o,
   output logic             rev_o,
   output logic [ECW-1:0]   err_cnt_o,
   output logic [ECW-1:0]   rev_cnt_o
);

   // State encoding. All four codes are used, so the state register has no
   // unreachable values.
   localparam logic [1:0] ST_EMPTY  = 2'd0;
   localparam logic [1:0] ST_PRIMED = 2'd1;
   localparam logic [1:0] ST_UP     = 2'd2;
   localparam logic [1:0] ST_DOWN   = 2'd3;

   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] STEP_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ECW-1:0]   ECNT_MAX = {ECW{1'b1}};
   localparam logic [ECW-1:0]   ECNT_ONE = {{(ECW-1){1'b0}}, 1'b1};

   // Saturating increment for the event counters: sticks at all-ones.
   function automatic logic [ECW-1:0] sat_inc(input logic [ECW-1:0] value);
      logic [ECW-1:0] result;
      if (value == ECNT_MAX) begin
         result = value;
      end else begin
         result = value + ECNT_ONE;
      end
      return result;
   endfunction

   // -----------------------------------------------------------------------
   // Registers and next-state values
   // -----------------------------------------------------------------------
   logic [1:0]       state_q,     state_d;
   logic [WIDTH-1:0] prev_q,      prev_d;
   logic             dir_q,       dir_d;
   logic             dir_valid_q, dir_valid_d;
   logic             hold_q,      hold_d;
   logic             step_err_q,  step_err_d;
   logic             wrap_up_q,   wrap_up_d;
   logic             wrap_down_q, wrap_down_d;
   logic             rev_q,       rev_d;
   logic [ECW-1:0]   err_cnt_q,   err_cnt_d;
   logic [ECW-1:0]   rev_cnt_q,   rev_cnt_d;

   // Step decode against the last enabled sample (modular subtraction, so
   // MAX->0 decodes as +1 and 0->MAX as -1 without special cases).
   logic [WIDTH-1:0] delta_s;
   logic             step_up_s;
   logic             step_down_s;
   logic             step_hold_s;

   // Decode the modular step between the current and the previous sample.
   always_comb begin
      delta_s     = count_in_i - prev_q;
      step_up_s   = (delta_s == STEP_ONE);
      step_down_s = (delta_s == CNT_MAX);
      step_hold_s = (delta_s == CNT_ZERO);
   end

   // Next-state logic: priming, step classification and event counting.
   always_comb begin
      // Registers hold and pulses clear unless an enabled sample says otherwise.
      state_d     = state_q;
      prev_d      = prev_q;
      dir_d       = dir_q;
      dir_valid_d = dir_valid_q;
      hold_d      = 1'b0;
      step_err_d  = 1'b0;
      wrap_up_d   = 1'b0;
      wrap_down_d = 1'b0;
      rev_d       = 1'b0;
      err_cnt_d   = err_cnt_q;
      rev_cnt_d   = rev_cnt_q;

      if (en_i) begin
         // The last enabled sample is always the new reference, so gaps in
         // en_i are invisible to the classification.
         prev_d = count_in_i;

         case (state_q)
            ST_EMPTY: begin
               // First sample after reset only primes the reference.
               state_d = ST_PRIMED;
            end

            ST_PRIMED, ST_UP, ST_DOWN: begin
               if (step_up_s) begin
                  dir_d       = 1'b1;
                  dir_valid_d = 1'b1;
                  state_d     = ST_UP;
                  // prev = MAX with a +1 step means the counter wrapped to 0.
                  wrap_up_d   = (prev_q == CNT_MAX);
                  if (state_q == ST_DOWN) begin
                     rev_d     = 1'b1;
                     rev_cnt_d = sat_inc(rev_cnt_q);
                  end else begin
                     rev_d     = 1'b0;
                  end
               end else if (step_down_s) begin
                  dir_d       = 1'b0;
                  dir_valid_d = 1'b1;
                  state_d     = ST_DOWN;
                  // prev = 0 with a -1 step means the counter wrapped to MAX.
                  wrap_down_d = (prev_q == CNT_ZERO);
                  if (state_q == ST_UP) begin
                     rev_d     = 1'b1;
                     rev_cnt_d = sat_inc(rev_cnt_q);
                  end else begin
                     rev_d     = 1'b0;
                  end
               end else if (step_hold_s) begin
                  // Direction knowledge survives a hold unchanged.
                  hold_d = 1'b1;
               end else begin
                  // Illegal step: forget the direction but keep dir_q so the
                  // last known value remains observable. Dropping to PRIMED
                  // means the next legal step re-establishes direction
                  // without being counted as a reversal.
                  step_err_d  = 1'b1;
                  err_cnt_d   = sat_inc(err_cnt_q);
                  dir_valid_d = 1'b0;
                  state_d     = ST_PRIMED;
               end
            end

            default: begin
               // Unreachable with a 2-bit encoding; recover to a clean start.
               state_d     = ST_EMPTY;
               dir_valid_d = 1'b0;
            end
         endcase
      end else begin
         // No sample this edge: everything holds and pulses stay low.
         prev_d  = prev_q;
         state_d = state_q;
      end
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_EMPTY;
         prev_q      <= {WIDTH{1'b0}};
         dir_q       <= 1'b0;
         dir_valid_q <= 1'b0;
         hold_q      <= 1'b0;
         step_err_q  <= 1'b0;
         wrap_up_q   <= 1'b0;
         wrap_down_q <= 1'b0;
         rev_q       <= 1'b0;
         err_cnt_q   <= {ECW{1'b0}};
         rev_cnt_q   <= {ECW{1'b0}};
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         dir_q       <= dir_d;
         dir_valid_q <= dir_valid_d;
         hold_q      <= hold_d;
         step_err_q  <= step_err_d;
         wrap_up_q   <= wrap_up_d;
         wrap_down_q <= wrap_down_d;
         rev_q       <= rev_d;
         err_cnt_q   <= err_cnt_d;
         rev_cnt_q   <= rev_cnt_d;
      end
   end

   // Outputs come straight from the registers.
   assign dir_o       = dir_q;
   assign dir_valid_o = dir_valid_q;
   assign hold_o      = hold_q;
   assign step_err_o  = step_err_q;
   assign wrap_up_o   = wrap_up_q;
   assign wrap_down_o = wrap_down_q;
   assign rev_o       = rev_q;
   assign err_cnt_o   = err_cnt_q;
   assign rev_cnt_o   = rev_cnt_q;

endmodule

// File: tb/tb_count_direction_decoder.sv
// ---------------------------------------------------------------------------
// tb_count_direction_decoder
//
// Directed-vector bench for count_direction_decoder. Each applied vector
// pushes its hand-computed expected outputs into a queue; an independent
// monitor pops one entry per clock on the falling edge and compares it with
// the DUT outputs.
// ---------------------------------------------------------------------------
module tb_count_direction_decoder;

   typedef struct packed {
      logic       dir;
      logic       dv;
      logic       hold;
      logic       serr;
      logic       wu;
      logic       wd;
      logic       rev;
      logic [7:0] ec;
      logic [7:0] rc;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       en;
   logic [7:0] count_in;
   logic       dir, dir_valid, hold, step_err, wrap_up, wrap_down, rev;
   logic [7:0] err_cnt, rev_cnt;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;

   count_direction_decoder #(.WIDTH(8), .ECW(8)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .en_i        (en),
      .count_in_i  (count_in),
      .dir_o       (dir),
      .dir_valid_o (dir_valid),
      .hold_o      (hold),
      .step_err_o  (step_err),
      .wrap_up_o   (wrap_up),
      .wrap_down_o (wrap_down),
      .rev_o       (rev),
      .err_cnt_o   (err_cnt),
      .rev_cnt_o   (rev_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: one expected entry per clock, compared on the falling edge.
   always @(negedge clk) begin
      exp_t  e;
      exp_t  a;
      string n;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         n = name_q.pop_front();
         a.dir  = dir;
         a.dv   = dir_valid;
         a.hold = hold;
         a.serr = step_err;
         a.wu   = wrap_up;
         a.wd   = wrap_down;
         a.rev  = rev;
         a.ec   = err_cnt;
         a.rc   = rev_cnt;
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s: got dir=%b dv=%b hold=%b serr=%b wu=%b wd=%b rev=%b ec=%0d rc=%0d, expected dir=%b dv=%b hold=%b serr=%b wu=%b wd=%b rev=%b ec=%0d rc=%0d",
                     n, a.dir, a.dv, a.hold, a.serr, a.wu, a.wd, a.rev, a.ec, a.rc,
                     e.dir, e.dv, e.hold, e.serr, e.wu, e.wd, e.rev, e.ec, e.rc);
         end
      end
   end

   // Apply one vector for one clock and queue the outputs expected after it.
   task automatic vec(input string nm, input logic r, input logic e, input logic [7:0] c,
                      input logic x_dir, input logic x_dv, input logic x_hold,
                      input logic x_serr, input logic x_wu, input logic x_wd,
                      input logic x_rev, input logic [7:0] x_ec, input logic [7:0] x_rc);
      exp_t x;
      rst      = r;
      en       = e;
      count_in = c;
      x.dir  = x_dir;
      x.dv   = x_dv;
      x.hold = x_hold;
      x.serr = x_serr;
      x.wu   = x_wu;
      x.wd   = x_wd;
      x.rev  = x_rev;
      x.ec   = x_ec;
      x.rc   = x_rc;
      @(posedge clk);
      exp_q.push_back(x);
      name_q.push_back(nm);
      #1;
   endtask

   initial begin
      rst      = 1'b1;
      en       = 1'b0;
      count_in = 8'd0;

      //            name           r     e     cnt     dir   dv    hold  serr  wu    wd    rev   ec      rc
      vec("reset",     1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      vec("reset_en",  1'b1, 1'b1, 8'd5,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

      // Counting up, then reversing.
      vec("prime0",    1'b0, 1'b1, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      vec("up1",       1'b0, 1'b1, 8'd1,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      vec("up2",       1'b0, 1'b1, 8'd2,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      vec("up3",       1'b0, 1'b1, 8'd3,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      vec("up4",       1'b0, 1'b1, 8'd4,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      vec("up5",       1'b0, 1'b1, 8'd5,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      vec("rev5to4",   1'b0, 1'b1, 8'd4,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1);
      vec("down3",     1'b0, 1'b1, 8'd3,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1);

      // Wrap up through MAX, then wrap down back through 0.
      vec("rst_w",     1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      vec("primeFE",   1'b0, 1'b1, 8'hFE,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      vec("upFF",      1'b0, 1'b1, 8'hFF,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      vec("wrapup00",  1'b0, 1'b1, 8'h00,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      vec("up01",      1'b0, 1'b1, 8'h01,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      vec("rev01to00", 1'b0, 1'b1, 8'h00,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1);
      vec("wrapdnFF",  1'b0, 1'b1, 8'hFF,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd1);
      vec("downFE",    1'b0, 1'b1, 8'hFE,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1);

      // Holds and illegal steps.
      vec("rst_h",     1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      vec("prime10",   1'b0, 1'b1, 8'd10,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      vec("hold10a",   1'b0, 1'b1, 8'd10,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      vec("hold10b",   1'b0, 1'b1, 8'd10,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      vec("up11",      1'b0, 1'b1, 8'd11,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      vec("err11to20", 1'b0, 1'b1, 8'd20,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0);
      vec("reest21",   1'b0, 1'b1, 8'd21,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0);
      vec("rev21to20", 1'b0, 1'b1, 8'd20,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1);
      vec("hold20dn",  1'b0, 1'b1, 8'd20,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1);

      // Enable gating: the disabled sample must not act as a reference.
      vec("err20to7",  1'b0, 1'b1, 8'd7,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 8'd1);
      vec("gap50",     1'b0, 1'b0, 8'd50,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd1);
      vec("step7to8",  1'b0, 1'b1, 8'd8,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd1);
      vec("gap99",     1'b0, 1'b0, 8'd99,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd1);
      vec("rev8to7",   1'b0, 1'b1, 8'd7,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 8'd2);

      // Saturation: 300 steps of +2, each illegal; err_cnt stops at 255.
      vec("rst_s",     1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      vec("prime_s",   1'b0, 1'b1, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      for (int k = 1; k <= 300; k++) begin
         logic [7:0] cv;
         logic [7:0] ev;
         cv = 8'((2 * k) % 256);
         ev = (k >= 255) ? 8'd255 : 8'(k);
         vec("sat_err", 1'b0, 1'b1, cv, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ev, 8'd0);
      end

      // Mid-stream reset while DOWN with rev_cnt = 3.
      vec("rst_m",     1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      vec("prime5",    1'b0, 1'b1, 8'd5,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      vec("m_up6",     1'b0, 1'b1, 8'd6,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      vec("m_rev5",    1'b0, 1'b1, 8'd5,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1);
      vec("m_rev6",    1'b0, 1'b1, 8'd6,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd2);
      vec("m_rev5b",   1'b0, 1'b1, 8'd5,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd3);
      vec("mid_rst",   1'b1, 1'b1, 8'd4,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      vec("reprime",   1'b0, 1'b1, 8'd200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      vec("after_dn",  1'b0, 1'b1, 8'd199, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

      en = 1'b0;

      // Bounded drain of the scoreboard.
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
